// File: rtl/round_key_store_if.sv
// ---------------------------------------------------------------------------
// round_key_store_if
//   Bundles the byte-serial key-load stream, the playback request and the
//   128-bit round-key output handshake of round_key_store.
//
//   master : driven by the surroundings (key expansion, cipher core control)
//   slave  : the round_key_store side
//
//   kb_in/kb_valid/kb_first : key byte stream, MSB byte of each word first
//   rd_start/rd_dir         : playback request and order (0 = 0..NR, 1 = NR..0)
//   rk_ready                : downstream accepts rk_data
//   rk_data/rk_valid/
//   rk_round/rk_last        : presented round key and its qualifiers
//   loaded/busy/rd_err      : status
// ---------------------------------------------------------------------------
interface round_key_store_if #(
   parameter int NR      = 10,
   parameter int ROUND_W = 4
);
   logic [7:0]         kb_in;
   logic               kb_valid;
   logic               kb_first;
   logic               rd_start;
   logic               rd_dir;
   logic               rk_ready;
   logic [127:0]       rk_data;
   logic               rk_valid;
   logic [ROUND_W-1:0] rk_round;
   logic               rk_last;
   logic               loaded;
   logic               busy;
   logic               rd_err;

   modport master (
      output kb_in, kb_valid, kb_first, rd_start, rd_dir, rk_ready,
      input  rk_data, rk_valid, rk_round, rk_last, loaded, busy, rd_err
   );

   modport slave (
      input  kb_in, kb_valid, kb_first, rd_start, rd_dir, rk_ready,
      output rk_data, rk_valid, rk_round, rk_last, loaded, busy, rd_err
   );
endinterface

// File: rtl/round_key_store.sv
// ---------------------------------------------------------------------------
// round_key_store
//   Consumer end of the byte-serial round-key stream. Packs MSB-first bytes
//   into 128-bit round keys, stores all NR+1 of them and plays them back one
//   per handshake, forward (encrypt) or reverse (decrypt).
//
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : round_key_store_if.slave (key stream in, round keys out, status)
//
//   A kb_first byte always wins: it aborts any playback and restarts the
//   fill. Key memory is not reset; loaded tells whether its contents are whole.
// ---------------------------------------------------------------------------
module round_key_store #(
   parameter int NR      = 10,
   parameter int ROUND_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   round_key_store_if.slave bus
);
   localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NR);
   localparam logic [ROUND_W-1:0] ZERO_IDX = ROUND_W'(0);
   localparam logic [ROUND_W-1:0] ONE_IDX  = ROUND_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      LOADED = 2'd2,
      READ   = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [119:0]       pack_r, pack_s;       // up to 15 bytes of the key being built
   logic [3:0]         byte_cnt_r, byte_cnt_s;
   logic [ROUND_W-1:0] wr_round_r, wr_round_s;
   logic [ROUND_W-1:0] rd_idx_r, rd_idx_s;
   logic               dir_r, dir_s;
   logic               loaded_r, loaded_s;
   logic               rk_valid_r, rk_valid_s;
   logic [127:0]       rk_data_r, rk_data_s;
   logic [ROUND_W-1:0] rk_round_r, rk_round_s;
   logic               rk_last_r, rk_last_s;
   logic               rd_err_r, rd_err_s;

   logic [127:0]       mem_r [0:NR];

   logic               first_s;
   logic               rd_accept_s;
   logic               xfer_s;
   logic               mem_we_s;
   logic [127:0]       wr_word_s;

   // True when idx is the final key of a playback running in direction dir.
   function automatic logic is_final(input logic [ROUND_W-1:0] idx, input logic dir);
      logic fin;
      if (dir) begin
         fin = (idx == ZERO_IDX);
      end else begin
         fin = (idx == LAST_IDX);
      end
      return fin;
   endfunction

   // Qualified events shared by the decode below.
   always_comb begin
      first_s     = bus.kb_valid & bus.kb_first;
      rd_accept_s = bus.rd_start & (state_r == LOADED) & ~first_s;
      xfer_s      = rk_valid_r & bus.rk_ready;
      wr_word_s   = {pack_r, bus.kb_in};
   end

   // Next-state and next-output decode for fill, playback and error reporting.
   always_comb begin
      state_s    = state_r;
      pack_s     = pack_r;
      byte_cnt_s = byte_cnt_r;
      wr_round_s = wr_round_r;
      rd_idx_s   = rd_idx_r;
      dir_s      = dir_r;
      loaded_s   = loaded_r;
      rk_valid_s = rk_valid_r;
      rk_data_s  = rk_data_r;
      rk_round_s = rk_round_r;
      rk_last_s  = rk_last_r;
      mem_we_s   = 1'b0;
      rd_err_s   = bus.rd_start & ~rd_accept_s;

      if (first_s) begin
         // New schedule: drop any playback and start packing round key 0.
         state_s    = FILL;
         pack_s     = {112'd0, bus.kb_in};
         byte_cnt_s = 4'd1;
         wr_round_s = ZERO_IDX;
         loaded_s   = 1'b0;
         rk_valid_s = 1'b0;
         rk_data_s  = 128'd0;
         rk_round_s = ZERO_IDX;
         rk_last_s  = 1'b0;
      end else begin
         case (state_r)
            FILL: begin
               if (bus.kb_valid) begin
                  pack_s = {pack_r[111:0], bus.kb_in};
                  if (byte_cnt_r == 4'd15) begin
                     mem_we_s   = 1'b1;
                     byte_cnt_s = 4'd0;
                     wr_round_s = wr_round_r + ONE_IDX;
                     if (wr_round_r == LAST_IDX) begin
                        loaded_s = 1'b1;
                        state_s  = LOADED;
                     end else begin
                        state_s  = FILL;
                     end
                  end else begin
                     byte_cnt_s = byte_cnt_r + 4'd1;
                  end
               end else begin
                  pack_s = pack_r;
               end
            end
            LOADED: begin
               if (rd_accept_s) begin
                  dir_s      = bus.rd_dir;
                  rd_idx_s   = bus.rd_dir ? LAST_IDX : ZERO_IDX;
                  rk_valid_s = 1'b1;
                  rk_data_s  = mem_r[rd_idx_s];
                  rk_round_s = rd_idx_s;
                  rk_last_s  = is_final(rd_idx_s, bus.rd_dir);
                  state_s    = READ;
               end else begin
                  state_s    = LOADED;
               end
            end
            READ: begin
               if (xfer_s) begin
                  if (rk_last_r) begin
                     // Final key taken; keys stay stored for another playback.
                     rk_valid_s = 1'b0;
                     rk_data_s  = 128'd0;
                     rk_round_s = ZERO_IDX;
                     rk_last_s  = 1'b0;
                     state_s    = LOADED;
                  end else begin
                     rd_idx_s   = dir_r ? (rd_idx_r - ONE_IDX) : (rd_idx_r + ONE_IDX);
                     rk_data_s  = mem_r[rd_idx_s];
                     rk_round_s = rd_idx_s;
                     rk_last_s  = is_final(rd_idx_s, dir_r);
                  end
               end else begin
                  state_s = READ;
               end
            end
            IDLE: begin
               state_s = IDLE;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         pack_r     <= 120'd0;
         byte_cnt_r <= 4'd0;
         wr_round_r <= ZERO_IDX;
         rd_idx_r   <= ZERO_IDX;
         dir_r      <= 1'b0;
         loaded_r   <= 1'b0;
         rk_valid_r <= 1'b0;
         rk_data_r  <= 128'd0;
         rk_round_r <= ZERO_IDX;
         rk_last_r  <= 1'b0;
         rd_err_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         pack_r     <= pack_s;
         byte_cnt_r <= byte_cnt_s;
         wr_round_r <= wr_round_s;
         rd_idx_r   <= rd_idx_s;
         dir_r      <= dir_s;
         loaded_r   <= loaded_s;
         rk_valid_r <= rk_valid_s;
         rk_data_r  <= rk_data_s;
         rk_round_r <= rk_round_s;
         rk_last_r  <= rk_last_s;
         rd_err_r   <= rd_err_s;
      end
   end

   // Round-key storage; written on the 16th byte of each key, never reset.
   always_ff @(posedge clk) begin
      if (mem_we_s && !rst) begin
         mem_r[wr_round_r] <= wr_word_s;
      end
   end

   assign bus.rk_data  = rk_data_r;
   assign bus.rk_valid = rk_valid_r;
   assign bus.rk_round = rk_round_r;
   assign bus.rk_last  = rk_last_r;
   assign bus.loaded   = loaded_r;
   assign bus.busy     = (state_r == FILL) || (state_r == READ);
   assign bus.rd_err   = rd_err_r;

endmodule

// File: tb/tb_round_key_store.sv
// ---------------------------------------------------------------------------
// tb_round_key_store
//   Streams key schedules into round_key_store, plays them back and checks
//   every presented key against a scoreboard filled from a plain array model
//   of the stored schedule.
// ---------------------------------------------------------------------------
module tb_round_key_store;
   localparam int NR = 10;

   typedef struct packed {
      logic [3:0]   round;
      logic [127:0] data;
      logic         last;
   } exp_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   logic [127:0] stim_keys  [0:NR];
   logic [127:0] model_keys [0:NR];
   exp_t         exp_q [$];

   round_key_store_if #(.NR(NR), .ROUND_W(4)) ifc ();

   round_key_store #(.NR(NR), .ROUND_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every transfer with the scoreboard and check that a
   // stalled key stays frozen and that an idle output reads zero.
   exp_t held;
   bit   stalled;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stalled = 1'b0;
      end else if (ifc.rk_valid) begin
         if (stalled) begin
            check("stall_data", ifc.rk_data, held.data);
            check("stall_round", 128'(ifc.rk_round), 128'(held.round));
         end
         if (ifc.rk_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_key: got round %0d data %h expected none",
                        ifc.rk_round, ifc.rk_data);
            end else begin
               e = exp_q.pop_front();
               check("key_data", ifc.rk_data, e.data);
               check("key_round", 128'(ifc.rk_round), 128'(e.round));
               check("key_last", 128'(ifc.rk_last), 128'(e.last));
            end
            stalled = 1'b0;
         end else begin
            stalled    = 1'b1;
            held.round = ifc.rk_round;
            held.data  = ifc.rk_data;
            held.last  = ifc.rk_last;
         end
      end else begin
         check("idle_data", ifc.rk_data, 128'd0);
         stalled = 1'b0;
      end
   end

   // Stream the first nbytes of stim_keys, MSB byte first, with random gaps.
   task automatic stream(input int nbytes);
      logic [3:0] wi;
      for (int i = 0; i < nbytes; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            ifc.kb_valid = 1'b0;
            tick();
         end
         if (i == 100) check("busy_fill", 128'(ifc.busy), 128'd1);
         if (i == 175) check("loaded_early", 128'(ifc.loaded), 128'd0);
         wi           = 4'(i / 16);
         ifc.kb_in    = 8'(stim_keys[wi] >> (8 * (15 - (i % 16))));
         ifc.kb_first = (i == 0);
         ifc.kb_valid = 1'b1;
         tick();
      end
      ifc.kb_valid = 1'b0;
      ifc.kb_first = 1'b0;
      if (nbytes == 176) begin
         for (int k = 0; k <= NR; k++) model_keys[k] = stim_keys[k];
         check("loaded_set", 128'(ifc.loaded), 128'd1);
         check("busy_after_fill", 128'(ifc.busy), 128'd0);
      end
   endtask

   task automatic random_keys;
      for (int k = 0; k <= NR; k++) stim_keys[k] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Accepted playback request: queue the expected keys in playback order.
   task automatic start_read(input logic dir);
      exp_t e;
      ifc.rd_start = 1'b1;
      ifc.rd_dir   = dir;
      for (int k = 0; k <= NR; k++) begin
         e.round = dir ? 4'(NR - k) : 4'(k);
         e.data  = model_keys[e.round];
         e.last  = (k == NR);
         exp_q.push_back(e);
      end
      tick();
      ifc.rd_start = 1'b0;
   endtask

   // Drive rk_ready until the scoreboard drains; optional 5-cycle stall and
   // an optional rejected rd_start during the playback.
   task automatic drain(input bit rnd, input int stall_at, input int err_at, output int cycles);
      cycles = 0;
      while (exp_q.size() != 0 && cycles < 300) begin
         if (stall_at >= 0 && cycles >= stall_at && cycles < stall_at + 5) ifc.rk_ready = 1'b0;
         else if (rnd) ifc.rk_ready = 1'($urandom_range(0, 1));
         else ifc.rk_ready = 1'b1;
         ifc.rd_start = (err_at >= 0 && cycles == err_at);
         tick();
         cycles++;
         if (err_at >= 0 && cycles == err_at + 1) check("rd_err_read", 128'(ifc.rd_err), 128'd1);
         if (err_at >= 0 && cycles == err_at + 2) check("rd_err_once", 128'(ifc.rd_err), 128'd0);
      end
      ifc.rd_start = 1'b0;
      ifc.rk_ready = 1'b1;
      if (cycles >= 300) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d keys pending expected 0", exp_q.size());
         exp_q.delete();
      end else begin
         check("rk_valid_end", 128'(ifc.rk_valid), 128'd0);
         check("busy_end", 128'(ifc.busy), 128'd0);
      end
   endtask

   task automatic rejected_start(input string name);
      ifc.rd_start = 1'b1;
      tick();
      ifc.rd_start = 1'b0;
      check(name, 128'(ifc.rd_err), 128'd1);
      tick();
      check({name, "_once"}, 128'(ifc.rd_err), 128'd0);
      check({name, "_valid"}, 128'(ifc.rk_valid), 128'd0);
   endtask

   initial begin
      int cycles;
      vectors      = 0;
      miscompares  = 0;
      rst          = 1'b1;
      ifc.kb_in    = 8'd0;
      ifc.kb_valid = 1'b0;
      ifc.kb_first = 1'b0;
      ifc.rd_start = 1'b0;
      ifc.rd_dir   = 1'b0;
      ifc.rk_ready = 1'b1;
      stim_keys = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
                    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      repeat (3) tick();
      rst = 1'b0;
      check("rst_valid", 128'(ifc.rk_valid), 128'd0);
      check("rst_data", ifc.rk_data, 128'd0);
      check("rst_round", 128'(ifc.rk_round), 128'd0);
      check("rst_last", 128'(ifc.rk_last), 128'd0);
      check("rst_loaded", 128'(ifc.loaded), 128'd0);
      check("rst_busy", 128'(ifc.busy), 128'd0);
      check("rst_rd_err", 128'(ifc.rd_err), 128'd0);

      // Playback requested before anything is loaded.
      rejected_start("rd_err_idle");

      // FIPS-197 schedule, forward at full throughput.
      stream(176);
      start_read(1'b0);
      drain(1'b0, -1, -1, cycles);
      check("fwd_throughput", 128'(cycles), 128'd11);

      // Reverse with a 5-cycle stall and a rejected rd_start mid-read.
      start_read(1'b1);
      drain(1'b1, 3, 6, cycles);

      // Keys retained: forward again with random backpressure.
      start_read(1'b0);
      drain(1'b1, -1, -1, cycles);

      // kb_first during playback aborts it.
      start_read(1'b0);
      ifc.rk_ready = 1'b1;
      tick();
      tick();
      ifc.rk_ready = 1'b0;
      ifc.kb_in    = 8'($urandom);
      ifc.kb_valid = 1'b1;
      ifc.kb_first = 1'b1;
      exp_q.delete();
      tick();
      ifc.kb_valid = 1'b0;
      ifc.kb_first = 1'b0;
      check("abort_valid", 128'(ifc.rk_valid), 128'd0);
      check("abort_loaded", 128'(ifc.loaded), 128'd0);
      check("abort_busy", 128'(ifc.busy), 128'd1);
      random_keys();
      stream(176);
      start_read(1'b1);
      drain(1'b1, -1, -1, cycles);

      // rd_start clashing with kb_first: rejected, fill starts.
      ifc.rd_start = 1'b1;
      ifc.kb_in    = 8'($urandom);
      ifc.kb_valid = 1'b1;
      ifc.kb_first = 1'b1;
      tick();
      ifc.rd_start = 1'b0;
      ifc.kb_valid = 1'b0;
      ifc.kb_first = 1'b0;
      check("rd_err_clash", 128'(ifc.rd_err), 128'd1);
      check("clash_loaded", 128'(ifc.loaded), 128'd0);
      check("clash_busy", 128'(ifc.busy), 128'd1);

      // kb_first mid-fill, then reset mid-fill.
      random_keys();
      stream(50);
      stream(120);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_fill_loaded", 128'(ifc.loaded), 128'd0);
      check("rst_fill_busy", 128'(ifc.busy), 128'd0);
      rejected_start("rd_err_after_rst");

      // Refill with a fresh schedule and play both ways.
      random_keys();
      stream(176);
      start_read(1'b0);
      drain(1'b1, 2, -1, cycles);
      start_read(1'b1);
      drain(1'b0, -1, -1, cycles);
      check("rev_throughput", 128'(cycles), 128'd11);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
